// File: rtl/wshb_arbiter.sv
// Round-robin arbiter that shares one Wishbone classic slave between two masters.
// A hold counter bounds each master's tenure whenever the other master is waiting.
module wshb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_HOLD   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic                    m0_ack,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic                    m1_ack,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic                    s_ack,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,

  output logic [1:0]              grant
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          last_reg, last_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          hold_spent;

  // Once the tenure budget is used up, any ack is a legal handover point.
  assign hold_spent = s_ack && (hold_cnt_reg >= HOLD_LAST);

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_next = last_reg ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          state_next = GNT0;
        end else if (m1_cyc) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          state_next = m1_cyc ? GNT1 : IDLE;
        end else if (hold_spent && m1_cyc) begin
          state_next = GNT1;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          state_next = m0_cyc ? GNT0 : IDLE;
        end else if (hold_spent && m0_cyc) begin
          state_next = GNT0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state_reg) begin
      hold_cnt_next = '0;
      if (state_next == GNT0) begin
        last_next = 1'b0;
      end else if (state_next == GNT1) begin
        last_next = 1'b1;
      end
    end else if ((state_reg != IDLE) && s_ack && (hold_cnt_reg != HOLD_MAX)) begin
      hold_cnt_next = hold_cnt_reg + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Output mux is purely a function of the registered owner, so reset releases the bus at once.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state_reg)
      GNT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        m0_ack  = s_ack;
      end
      GNT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        m1_ack  = s_ack;
      end
      default: begin
      end
    endcase
  end

  assign grant    = {state_reg == GNT1, state_reg == GNT0};
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

endmodule
